// File: rtl/pe_tilde_seq_if.sv
// Command, memory-address and PE-strobe bundle for the PE_Tilde lane sequencer.
// The slave modport is the sequencer; the master modport is the stage control / memory side.
interface pe_tilde_seq_if #(
  parameter int LOGN_MAX  = 6,
  parameter int TW_ADDR_W = 8
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [2:0]           cmd_logn;
  logic [TW_ADDR_W-1:0] cmd_tw_base;
  logic                 abort;
  logic                 rd_en;
  logic [LOGN_MAX-1:0]  rd_addr;
  logic [TW_ADDR_W-1:0] tw_addr;
  logic                 pe_start;
  logic                 wr_en;
  logic [LOGN_MAX-1:0]  wr_addr;
  logic                 busy;
  logic                 done;
  logic                 cmd_err;

  modport slave (
    input  cmd_valid, cmd_logn, cmd_tw_base, abort,
    output cmd_ready, rd_en, rd_addr, tw_addr, pe_start,
           wr_en, wr_addr, busy, done, cmd_err
  );

  modport master (
    output cmd_valid, cmd_logn, cmd_tw_base, abort,
    input  cmd_ready, rd_en, rd_addr, tw_addr, pe_start,
           wr_en, wr_addr, busy, done, cmd_err
  );
endinterface

// File: rtl/pe_tilde_seq.sv
// Sequencer for one PE_Tilde butterfly lane: one NTT stage pass over 2^logn points,
// issuing reads/twiddle addresses, the PE start strobe and latency-matched write addresses.
module pe_tilde_seq #(
  parameter int LOGN_MAX  = 6,
  parameter int TW_ADDR_W = 8,
  parameter int RD_LAT    = 1,
  parameter int PIPE_LAT  = 14
) (
  input  logic clk,
  input  logic reset,
  pe_tilde_seq_if.slave bus
);
  localparam int CW = LOGN_MAX + 1;
  localparam int DL = RD_LAT + PIPE_LAT;

  typedef enum logic [1:0] {ST_IDLE, ST_FEED, ST_DRAIN, ST_DONE} state_t;

  state_t               state_q, state_d;
  logic [2:0]           logn_q;
  logic [TW_ADDR_W-1:0] tw_base_q;
  logic [CW-1:0]        rd_cnt, wr_cnt, last_idx;
  logic [DL-1:0]        dly;
  logic                 cmd_err_q;
  logic                 cmd_legal, accept, aborting;
  logic                 rd_en_w, wr_en_w;

  assign cmd_legal = (bus.cmd_logn != 3'd0) && (int'(bus.cmd_logn) <= LOGN_MAX);
  assign accept    = (state_q == ST_IDLE) && bus.cmd_valid;
  assign aborting  = bus.abort && (state_q != ST_IDLE);
  assign last_idx  = (CW'(1) << logn_q) - CW'(1);
  assign rd_en_w   = (state_q == ST_FEED);
  // One shared shift line: tap RD_LAT-1 feeds the PE, the final tap marks ntt_o valid.
  assign wr_en_w   = dly[DL-1];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept && cmd_legal) state_d = ST_FEED;
      ST_FEED:  if (rd_cnt == last_idx) state_d = ST_DRAIN;
      // Leave on the last write itself so done lands the cycle after it.
      ST_DRAIN: if (wr_en_w && (wr_cnt == last_idx)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (aborting) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      logn_q    <= '0;
      tw_base_q <= '0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      dly       <= '0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_err_q <= accept && !cmd_legal;
      if (accept) begin
        logn_q    <= bus.cmd_logn;
        tw_base_q <= bus.cmd_tw_base;
      end
      if (aborting) dly <= '0;
      else          dly <= {dly[DL-2:0], rd_en_w};
      rd_cnt <= (rd_en_w && !aborting) ? rd_cnt + CW'(1) : '0;
      if (aborting || (state_q == ST_IDLE) || (state_q == ST_DONE)) wr_cnt <= '0;
      else if (wr_en_w)                                             wr_cnt <= wr_cnt + CW'(1);
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.cmd_err   = cmd_err_q;
  assign bus.rd_en     = rd_en_w;
  assign bus.rd_addr   = rd_en_w ? rd_cnt[LOGN_MAX-1:0] : '0;
  assign bus.tw_addr   = rd_en_w ? tw_base_q + TW_ADDR_W'(rd_cnt >> 1) : '0;
  assign bus.pe_start  = dly[RD_LAT-1];
  assign bus.wr_en     = wr_en_w;
  assign bus.wr_addr   = wr_cnt[LOGN_MAX-1:0];
endmodule

// File: tb/tb_pe_tilde_seq.sv
// Directed bench for pe_tilde_seq: a table of key cycles for a logn=3 pass,
// a per-cycle model check for full passes, and hand-written error/abort/reset/back-to-back sequences.
module tb_pe_tilde_seq;
  localparam int LOGN_MAX  = 6;
  localparam int TW_ADDR_W = 8;
  localparam int RD_LAT    = 1;
  localparam int PIPE_LAT  = 14;
  localparam int LAT       = RD_LAT + PIPE_LAT;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  pe_tilde_seq_if #(.LOGN_MAX(LOGN_MAX), .TW_ADDR_W(TW_ADDR_W)) ifc ();

  pe_tilde_seq #(
    .LOGN_MAX (LOGN_MAX),
    .TW_ADDR_W(TW_ADDR_W),
    .RD_LAT   (RD_LAT),
    .PIPE_LAT (PIPE_LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rd_en;
    logic [5:0] rd_addr;
    logic [7:0] tw_addr;
    logic       pe_start;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic       done;
    logic       cmd_ready;
    logic       busy;
  } obs_t;

  // -1 marks a field that is not checked at that cycle
  typedef struct {
    int cyc;
    int rd_en;
    int rd_addr;
    int tw_addr;
    int pe_start;
    int wr_en;
    int wr_addr;
    int done;
    int cmd_ready;
    int busy;
  } vec_t;

  obs_t snap [0:63];
  vec_t tbl  [0:13];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_chk++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.rd_en     = ifc.rd_en;
    o.rd_addr   = ifc.rd_addr;
    o.tw_addr   = ifc.tw_addr;
    o.pe_start  = ifc.pe_start;
    o.wr_en     = ifc.wr_en;
    o.wr_addr   = ifc.wr_addr;
    o.done      = ifc.done;
    o.cmd_ready = ifc.cmd_ready;
    o.busy      = ifc.busy;
    return o;
  endfunction

  // Issues a command at the current negedge (cycle 0) and records cycles 0..ncyc-1.
  task automatic capture_pass(input int logn, input int base, input int ncyc);
    ifc.cmd_valid   = 1'b1;
    ifc.cmd_logn    = 3'(logn);
    ifc.cmd_tw_base = 8'(base);
    for (int c = 0; c < ncyc; c++) begin
      snap[c] = sample();
      step();
      if (c == 0) ifc.cmd_valid = 1'b0;
    end
  endtask

  // Full pass checked against closed-form timing derived from the latencies.
  task automatic run_model(input string tag, input int logn, input int base);
    int n;
    int wr_seen;
    n = 1 << logn;
    wr_seen = 0;
    chk({tag, " ready@0"}, ifc.cmd_ready, 1);
    ifc.cmd_valid   = 1'b1;
    ifc.cmd_logn    = 3'(logn);
    ifc.cmd_tw_base = 8'(base);
    for (int c = 0; c <= n + LAT + 2; c++) begin
      bit e_rd, e_pe, e_wr;
      e_rd = (c >= 1) && (c <= n);
      e_pe = (c >= 1 + RD_LAT) && (c <= n + RD_LAT);
      e_wr = (c >= 1 + LAT) && (c <= n + LAT);
      chk($sformatf("%s rd_en c%0d", tag, c), ifc.rd_en, int'(e_rd));
      if (e_rd) begin
        chk($sformatf("%s rd_addr c%0d", tag, c), ifc.rd_addr, c - 1);
        chk($sformatf("%s tw_addr c%0d", tag, c), ifc.tw_addr, (base + (c - 1) / 2) % 256);
      end
      chk($sformatf("%s pe_start c%0d", tag, c), ifc.pe_start, int'(e_pe));
      chk($sformatf("%s wr_en c%0d", tag, c), ifc.wr_en, int'(e_wr));
      if (e_wr) begin
        chk($sformatf("%s wr_addr c%0d", tag, c), ifc.wr_addr, c - 1 - LAT);
        wr_seen++;
      end
      chk($sformatf("%s done c%0d", tag, c), ifc.done, int'(c == n + LAT + 1));
      chk($sformatf("%s busy c%0d", tag, c), ifc.busy, int'((c >= 1) && (c <= n + LAT + 1)));
      step();
      if (c == 0) ifc.cmd_valid = 1'b0;
    end
    chk({tag, " write count"}, wr_seen, n);
  endtask

  task automatic err_cmd(input string tag, input int logn);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_logn  = 3'(logn);
    step();
    ifc.cmd_valid = 1'b0;
    chk({tag, " cmd_err pulse"}, ifc.cmd_err, 1);
    chk({tag, " busy"}, ifc.busy, 0);
    chk({tag, " rd_en"}, ifc.rd_en, 0);
    chk({tag, " ready"}, ifc.cmd_ready, 1);
    step();
    chk({tag, " cmd_err low"}, ifc.cmd_err, 0);
    chk({tag, " busy after"}, ifc.busy, 0);
    chk({tag, " rd_en after"}, ifc.rd_en, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt_wr, cnt_done, cnt_acc, acc2, pe1, pe2, rdy_busy;
    n_chk  = 0;
    n_fail = 0;

    // logn=3, base=5, cmd at cycle 0
    tbl[0]  = '{0,  0, -1, -1, 0, 0, -1, 0, 1, 0};
    tbl[1]  = '{1,  1,  0,  5, 0, 0, -1, 0, 0, 1};
    tbl[2]  = '{2,  1,  1,  5, 1, 0, -1, 0, 0, 1};
    tbl[3]  = '{3,  1,  2,  6, 1, 0, -1, 0, 0, 1};
    tbl[4]  = '{5,  1,  4,  7, 1, 0, -1, 0, 0, 1};
    tbl[5]  = '{8,  1,  7,  8, 1, 0, -1, 0, 0, 1};
    tbl[6]  = '{9,  0, -1, -1, 1, 0, -1, 0, 0, 1};
    tbl[7]  = '{10, 0, -1, -1, 0, 0, -1, 0, 0, 1};
    tbl[8]  = '{15, 0, -1, -1, 0, 0, -1, 0, 0, 1};
    tbl[9]  = '{16, 0, -1, -1, 0, 1,  0, 0, 0, 1};
    tbl[10] = '{17, 0, -1, -1, 0, 1,  1, 0, 0, 1};
    tbl[11] = '{23, 0, -1, -1, 0, 1,  7, 0, 0, 1};
    tbl[12] = '{24, 0, -1, -1, 0, 0, -1, 1, 0, 1};
    tbl[13] = '{25, 0, -1, -1, 0, 0, -1, 0, 1, 0};

    reset           = 1'b1;
    ifc.cmd_valid   = 1'b0;
    ifc.cmd_logn    = '0;
    ifc.cmd_tw_base = '0;
    ifc.abort       = 1'b0;
    @(negedge clk);
    repeat (3) step();

    chk("reset cmd_ready", ifc.cmd_ready, 1);
    chk("reset busy",      ifc.busy,      0);
    chk("reset rd_en",     ifc.rd_en,     0);
    chk("reset pe_start",  ifc.pe_start,  0);
    chk("reset wr_en",     ifc.wr_en,     0);
    chk("reset done",      ifc.done,      0);
    chk("reset cmd_err",   ifc.cmd_err,   0);
    chk("reset rd_addr",   ifc.rd_addr,   0);
    chk("reset tw_addr",   ifc.tw_addr,   0);
    chk("reset wr_addr",   ifc.wr_addr,   0);
    reset = 1'b0;
    step();

    // T1: table of key cycles
    capture_pass(3, 5, 30);
    for (int i = 0; i < 14; i++) begin
      obs_t o;
      o = snap[tbl[i].cyc];
      chk($sformatf("T1 rd_en c%0d", tbl[i].cyc), o.rd_en, tbl[i].rd_en);
      if (tbl[i].rd_addr >= 0) chk($sformatf("T1 rd_addr c%0d", tbl[i].cyc), o.rd_addr, tbl[i].rd_addr);
      if (tbl[i].tw_addr >= 0) chk($sformatf("T1 tw_addr c%0d", tbl[i].cyc), o.tw_addr, tbl[i].tw_addr);
      chk($sformatf("T1 pe_start c%0d", tbl[i].cyc), o.pe_start, tbl[i].pe_start);
      chk($sformatf("T1 wr_en c%0d", tbl[i].cyc), o.wr_en, tbl[i].wr_en);
      if (tbl[i].wr_addr >= 0) chk($sformatf("T1 wr_addr c%0d", tbl[i].cyc), o.wr_addr, tbl[i].wr_addr);
      chk($sformatf("T1 done c%0d", tbl[i].cyc), o.done, tbl[i].done);
      chk($sformatf("T1 cmd_ready c%0d", tbl[i].cyc), o.cmd_ready, tbl[i].cmd_ready);
      chk($sformatf("T1 busy c%0d", tbl[i].cyc), o.busy, tbl[i].busy);
    end

    // T2: maximum size, twiddle address wraps
    run_model("T2", 6, 8'hFE);

    // T3: illegal sizes
    err_cmd("T3 logn0", 0);
    err_cmd("T3 logn7", 7);

    // T4: abort mid-FEED at cycle 10
    ifc.cmd_valid   = 1'b1;
    ifc.cmd_logn    = 3'd4;
    ifc.cmd_tw_base = 8'd0;
    for (int c = 0; c < 10; c++) begin
      step();
      ifc.cmd_valid = 1'b0;
    end
    chk("T4 rd_en before abort", ifc.rd_en, 1);
    ifc.abort = 1'b1;
    step();
    ifc.abort = 1'b0;
    chk("T4 ready after abort",    ifc.cmd_ready, 1);
    chk("T4 busy after abort",     ifc.busy,      0);
    chk("T4 rd_en after abort",    ifc.rd_en,     0);
    chk("T4 pe_start after abort", ifc.pe_start,  0);
    cnt_wr = 0;
    cnt_done = 0;
    for (int c = 11; c < 40; c++) begin
      if (ifc.wr_en === 1'b1) cnt_wr++;
      if (ifc.done === 1'b1) cnt_done++;
      step();
    end
    chk("T4 wr_en after abort", cnt_wr,   0);
    chk("T4 done after abort",  cnt_done, 0);
    run_model("T4 next", 2, 3);

    // T5: reset in DRAIN
    ifc.cmd_valid   = 1'b1;
    ifc.cmd_logn    = 3'd3;
    ifc.cmd_tw_base = 8'd9;
    for (int c = 0; c < 12; c++) begin
      step();
      ifc.cmd_valid = 1'b0;
    end
    chk("T5 busy in drain", ifc.busy, 1);
    reset = 1'b1;
    step();
    chk("T5 cmd_ready", ifc.cmd_ready, 1);
    chk("T5 busy",      ifc.busy,      0);
    chk("T5 rd_en",     ifc.rd_en,     0);
    chk("T5 pe_start",  ifc.pe_start,  0);
    chk("T5 wr_en",     ifc.wr_en,     0);
    chk("T5 wr_addr",   ifc.wr_addr,   0);
    chk("T5 done",      ifc.done,      0);
    chk("T5 cmd_err",   ifc.cmd_err,   0);
    reset = 1'b0;
    cnt_wr = 0;
    cnt_done = 0;
    for (int c = 0; c < 25; c++) begin
      step();
      if (ifc.wr_en === 1'b1) cnt_wr++;
      if (ifc.done === 1'b1) cnt_done++;
    end
    chk("T5 wr_en after reset", cnt_wr,   0);
    chk("T5 done after reset",  cnt_done, 0);

    // T6: cmd_valid held across two logn=1 passes (19-cycle period)
    ifc.cmd_valid   = 1'b1;
    ifc.cmd_logn    = 3'd1;
    ifc.cmd_tw_base = 8'd0;
    cnt_acc = 0; acc2 = -1; pe1 = 0; pe2 = 0; cnt_done = 0; rdy_busy = 0;
    for (int c = 0; c < 38; c++) begin
      if (ifc.cmd_ready === 1'b1 && ifc.cmd_valid) begin
        cnt_acc++;
        if (c > 0) acc2 = c;
      end
      if (ifc.pe_start === 1'b1) begin
        if (c < 19) pe1++;
        else        pe2++;
      end
      if (ifc.done === 1'b1) cnt_done++;
      if (ifc.cmd_ready === 1'b1 && ifc.busy === 1'b1) rdy_busy++;
      if (c == 18) chk("T6 done first pass", ifc.done, 1);
      if (c == 37) begin
        chk("T6 done second pass", ifc.done, 1);
        ifc.cmd_valid = 1'b0;
      end
      step();
    end
    chk("T6 accepts",          cnt_acc,  2);
    chk("T6 second accept",    acc2,     19);
    chk("T6 pe_start pass 1",  pe1,      2);
    chk("T6 pe_start pass 2",  pe2,      2);
    chk("T6 done count",       cnt_done, 2);
    chk("T6 ready while busy", rdy_busy, 0);
    chk("T6 idle at end",      ifc.cmd_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
